bk_stream_accum: RTL
====================

Name: bk_stream_accum

Overview:
- Streaming accumulator that feeds the 12-bit interleaved-operand Brent-Kung adder and consumes its 13-bit result.
- Sits directly around that adder:
  - drives the adder's 24-bit operand bus from an internal accumulator and the incoming data beat;
  - registers the adder's sum/carry back into the accumulator.
- Extends the sum with a saturating high counter.
- Emits one result per frame (frame delimited by in_last) over a valid/ready handshake.

Parameters:
- OPW, 12, operand width; fixed by the adder (adder bus is 2*OPW, result OPW+1).
- HI_W, 4, width of the carry-extension field; out_sum is OPW+HI_W bits.
- CNT_W, 8, width of the per-frame beat counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  data beat valid.
- in_ready  out  1  accumulator can accept a beat.
- in_data  in  OPW  unsigned operand.
- in_last  in  1  final beat of the frame.
- adder_in  out  2*OPW  operand bus to the adder. Bit 2i = accumulator operand bit i, bit 2i+1 = in_data bit i.
- adder_out  in  OPW+1  adder result. Bit OPW is carry-out.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  OPW+HI_W  frame sum, saturating.
- out_count  out  CNT_W  number of beats in the frame, saturating at all-ones.
- out_ovf  out  1  sum saturated during this frame.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; accumulator, hi, count, sat all 0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - in_ready=1 as soon as state is IDLE, including while reset is asserted.
- States:
  - IDLE: no beat of the current frame accepted yet.
  - ACCUM: at least one beat accepted, in_last not yet seen.
  - DONE: result presented on the output.
- in_ready = (state != DONE). A beat is accepted when in_valid & in_ready.
- Accumulator operand on adder_in is 0 in IDLE and acc in ACCUM. The data operand is always in_data. adder_in is combinational; it is only meaningful on an accept cycle.
- On accept, with no saturation in effect:
  - acc <= adder_out[OPW-1:0];
  - hi <= hi + adder_out[OPW], where hi is the HI_W-bit upper field;
  - count <= (state==IDLE) ? 1 : sat_inc(count).
- Saturation:
  - Condition: hi is all-ones and adder_out[OPW]=1, or sat is already set.
  - Effect: sat <= 1, acc and hi held at all-ones. Further beats only advance count.
  - sat clears when a new frame starts.
- Transitions:
  - IDLE to ACCUM on accept with in_last=0.
  - IDLE or ACCUM to DONE on accept with in_last=1.
  - DONE to IDLE on out_valid & out_ready.
- Output timing:
  - out_valid=1 exactly while in DONE. Latency is 1 cycle: last beat accepted at edge t gives out_valid high after edge t.
  - out_sum={hi,acc}, out_count and out_ovf are stable throughout DONE.
- Backpressure: while out_ready=0 in DONE, all outputs are held and in_valid is ignored.
- Single-beat frame: IDLE accept with in_last=1 gives out_sum=in_data, out_count=1.
- Beat counter saturates at 2^CNT_W-1 without affecting the sum.
- Back-to-back frames:
  - minimum 1 idle-input cycle between frames, namely the DONE cycle;
  - throughput is N+1 cycles per N-beat frame when out_ready=1.
- Reset mid-frame discards all partial state; the next frame starts from zero.
- Adder assumed combinational and settled within one cycle. No internal timing check is performed.

Decomposition:
- Shared package bk_pkg holds:
  - OPW=12, ADDER_IN_W=24, ADDER_OUT_W=13;
  - state enum {IDLE, ACCUM, DONE};
  - function interleave(a,b) producing the adder bus ordering, shared with the adder's testbench.
- One sub-module: bk_operand_interleave. Purely combinational; two OPW-bit operands in, 2*OPW-bit interleaved bus out.

Test Plan:
- Single beat 0xABC, in_last=1, out_ready=1 -> out_valid high next cycle, out_sum=0x0ABC, out_count=1, out_ovf=0, then IDLE.
- Frame 0xFFF, 0x001, 0x800 (last) -> adder carry on beat 2; out_sum=0x1800, out_count=3, out_ovf=0.
- 17 beats of 0xFFF with HI_W=4:
  - after 16 beats sum=0xFFF0;
  - the 17th beat overflows;
  - out_sum=0xFFFF, out_ovf=1, out_count=17;
  - next frame starts with out_ovf=0.
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 -> in_ready=0, out_sum, out_count and out_valid unchanged; result is accepted on the first out_ready=1 cycle.
- Assert rst_n=0 asynchronously after 2 beats of a frame -> out_valid=0 immediately. Next frame 0x005 (last) gives out_sum=0x0005, out_count=1.
- Bus mapping check: IDLE with in_data=0x001 gives adder_in=24'h000002. In ACCUM with acc=0x001 and in_data=0x000, adder_in=24'h000001.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung streaming accumulator and its operand bus.
package bk_pkg;

  localparam int OPW         = 12;
  localparam int ADDER_IN_W  = 2 * OPW;
  localparam int ADDER_OUT_W = OPW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Adder bus ordering: even bits carry operand a, odd bits carry operand b.
  function automatic logic [ADDER_IN_W-1:0] interleave(input logic [OPW-1:0] a,
                                                       input logic [OPW-1:0] b);
    logic [ADDER_IN_W-1:0] bus;
    bus = '0;
    for (int i = 0; i < OPW; i++) begin
      bus[2*i]   = a[i];
      bus[2*i+1] = b[i];
    end
    return bus;
  endfunction

endpackage

// File: rtl/bk_operand_interleave.sv
// Combinational bit interleaver building the adder operand bus from two operands.
module bk_operand_interleave
  import bk_pkg::*;
#(
  parameter int W = bk_pkg::OPW
) (
  input  logic [W-1:0]   acc_op,
  input  logic [W-1:0]   data_op,
  output logic [2*W-1:0] bus
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign bus[2*gi]   = acc_op[gi];
    assign bus[2*gi+1] = data_op[gi];
  end

endmodule

// File: rtl/bk_stream_accum.sv
// Frame accumulator wrapped around an external interleaved-operand adder, with a
// saturating carry-extension field and beat counter, one result per frame.
module bk_stream_accum
  import bk_pkg::*;
#(
  parameter int OPW   = bk_pkg::OPW,
  parameter int HI_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       in_data,
  input  logic                 in_last,
  output logic [2*OPW-1:0]     adder_in,
  input  logic [OPW:0]         adder_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPW+HI_W-1:0]  out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf
);

  state_t             state_q, state_d;
  logic [OPW-1:0]     acc_q, acc_d;
  logic [HI_W-1:0]    hi_q, hi_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic               first_beat;
  logic               carry;
  logic [OPW-1:0]     acc_op;
  logic [HI_W-1:0]    hi_base;
  logic               sat_base;

  assign in_ready   = (state_q != DONE);
  assign accept     = in_valid & in_ready;
  assign first_beat = (state_q == IDLE);
  assign carry      = adder_out[OPW];

  // A new frame adds to zero, so the stale previous result never leaks in.
  assign acc_op   = (state_q == ACCUM) ? acc_q : '0;
  assign hi_base  = first_beat ? '0 : hi_q;
  assign sat_base = first_beat ? 1'b0 : sat_q;

  bk_operand_interleave #(.W(OPW)) u_interleave (
    .acc_op  (acc_op),
    .data_op (in_data),
    .bus     (adder_in)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    count_d = count_q;
    sat_d   = sat_q;
    if (accept) begin
      if (sat_base || ((&hi_base) && carry)) begin
        sat_d = 1'b1;
        acc_d = '1;
        hi_d  = '1;
      end else begin
        sat_d = 1'b0;
        acc_d = adder_out[OPW-1:0];
        hi_d  = hi_base + HI_W'(carry);
      end
      if (first_beat) begin
        count_d = CNT_W'(1);
      end else if (!(&count_q)) begin
        count_d = count_q + CNT_W'(1);
      end
      state_d = in_last ? DONE : ACCUM;
    end else if ((state_q == DONE) && out_ready) begin
      state_d = IDLE;
    end
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      hi_q        <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      hi_q        <= hi_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = {hi_q, acc_q};
  assign out_count = count_q;
  assign out_ovf   = sat_q;

endmodule
